// File: rtl/cache_read_checker.sv
// Read-data scoreboard for the cache test harness. Tracks every accepted read
// through an RD_LAT-deep return pipe, compares the returned cache line against
// an address-derived pattern and reports counts, first mismatch and pass/fail.
module cache_read_checker #(
  parameter int          RD_LAT = 1,
  parameter logic [31:0] SEED   = 32'hA5A5_5A5A,
  parameter int          CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  logic              r_i,
  input  logic [35:0]       addr_i,
  input  logic              mem_stall_in_i,
  input  logic [1:0]        flushtype_i,
  input  logic              chk_en_i,
  input  logic [127:0]      cache_data_i,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic              err_flag_o,
  output logic [35:0]       first_err_addr_o,
  output logic [127:0]      first_err_data_o,
  output logic              done_o,
  output logic              pass_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [RD_LAT-1:0]       vld_q, vld_d;
  logic [RD_LAT-1:0][31:0] adr_q, adr_d;
  logic [CNT_W-1:0]        rd_q, rd_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic                    flag_q, flag_d;
  logic [35:0]             faddr_q, faddr_d;
  logic [127:0]            fdata_q, fdata_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;

  logic                    accept, live, sample, mism;
  logic [31:0]             smp_adr;
  logic [127:0]            exp_data;

  // Byte offset within the line never takes part in the pattern.
  logic unused_nib;
  assign unused_nib = ^addr_i[3:0];

  // Next-state: return pipe, compare/count on sample, then FSM overrides.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    adr_d   = adr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    flag_d  = flag_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    done_d  = done_q;
    pass_d  = pass_q;

    accept   = (state_q == RUN) && go_i && r_i && !mem_stall_in_i;
    // Dropping go in RUN abandons the pipe, so nothing is compared that cycle.
    live     = ((state_q == RUN) && go_i) || (state_q == DRAIN);
    sample   = live && vld_q[RD_LAT-1] && !mem_stall_in_i;
    smp_adr  = adr_q[RD_LAT-1];
    exp_data = {4{smp_adr ^ SEED}};
    mism     = sample && chk_en_i && (cache_data_i != exp_data);

    // Pipe only moves on un-stalled cycles; stage0 takes the new accept.
    if (!mem_stall_in_i) begin
      for (int i = RD_LAT-1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        adr_d[i] = adr_q[i-1];
      end
      vld_d[0] = accept;
      adr_d[0] = addr_i[35:4];
    end

    if (sample && (rd_q != CNT_MAX)) rd_d = rd_q + CNT_ONE;
    if (mism) begin
      if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
      flag_d = 1'b1;
      if (!flag_q) begin
        faddr_d = {smp_adr, 4'h0};
        fdata_d = cache_data_i;
      end
    end

    case (state_q)
      IDLE: begin
        if (go_i) begin
          state_d = RUN;
          vld_d   = '0;
          rd_d    = '0;
          err_d   = '0;
          flag_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (!go_i) begin
          state_d = IDLE;
          vld_d   = '0;
        end else if (flushtype_i == 2'b11) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that retires the last read so done lines up
        // with the final counter update.
        if (vld_d == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = !flag_d;
        end
      end
      DONE: begin
        if (!go_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vld_q   <= '0;
      adr_q   <= '0;
      rd_q    <= '0;
      err_q   <= '0;
      flag_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      adr_q   <= adr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign rd_count_o       = rd_q;
  assign err_count_o      = err_q;
  assign err_flag_o       = flag_q;
  assign first_err_addr_o = faddr_q;
  assign first_err_data_o = fdata_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;

endmodule

// File: tb/tb_cache_read_checker.sv
// Bench for cache_read_checker: RD_LAT=1 instance driven from a vector table
// with a scoreboard queue, RD_LAT=3 instance for the drain corner case.
module tb_cache_read_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, go1, go3, r, stall, chk_en;
  logic [35:0]  addr;
  logic [1:0]   flushtype;
  logic [127:0] data1, data3;

  logic [15:0]  rd1, err1, rd3, err3;
  logic         flag1, flag3, done1, done3, pass1, pass3;
  logic [35:0]  fa1, fa3;
  logic [127:0] fd1, fd3;

  cache_read_checker #(.RD_LAT(1)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go1), .r_i(r), .addr_i(addr),
    .mem_stall_in_i(stall), .flushtype_i(flushtype), .chk_en_i(chk_en),
    .cache_data_i(data1), .rd_count_o(rd1), .err_count_o(err1),
    .err_flag_o(flag1), .first_err_addr_o(fa1), .first_err_data_o(fd1),
    .done_o(done1), .pass_o(pass1));

  cache_read_checker #(.RD_LAT(3)) d3 (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go3), .r_i(r), .addr_i(addr),
    .mem_stall_in_i(stall), .flushtype_i(flushtype), .chk_en_i(chk_en),
    .cache_data_i(data3), .rd_count_o(rd3), .err_count_o(err3),
    .err_flag_o(flag3), .first_err_addr_o(fa3), .first_err_data_o(fd3),
    .done_o(done3), .pass_o(pass3));

  typedef struct { logic [35:0] a; logic [127:0] d; logic ce; } vec_t;
  typedef struct { logic [15:0] rd; logic [15:0] err; logic flag;
                   logic [35:0] fa; logic [127:0] fd; } exp_t;

  vec_t tv [15];
  exp_t sbq [$];

  int n_chk = 0;
  int n_err = 0;

  logic [15:0]  m_rd, m_err;
  logic         m_flag;
  logic [35:0]  m_fa;
  logic [127:0] m_fd;

  function automatic logic [127:0] pat(input logic [35:0] a);
    logic [31:0] w;
    w = a[35:4] ^ 32'hA5A5_5A5A;
    return {w, w, w, w};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_rd = 0; m_err = 0; m_flag = 0; m_fa = 0; m_fd = 0;
  endtask

  task automatic start1();
    @(negedge clk) go1 = 1'b1;
    @(negedge clk);
    model_clear();
    chk("start_rd", {112'b0, rd1}, 128'd0);
    chk("start_done", {127'b0, done1}, 128'd0);
  endtask

  // One read on the RD_LAT=1 instance; expected state goes on the queue as
  // the read is driven, popped once rd_count moves.
  task automatic read1(input vec_t v);
    exp_t e;
    logic [15:0] prev;
    bit seen;
    m_rd++;
    if (v.ce && v.d != pat(v.a)) begin
      m_err++;
      if (!m_flag) begin m_fa = {v.a[35:4], 4'h0}; m_fd = v.d; end
      m_flag = 1'b1;
    end
    e.rd = m_rd; e.err = m_err; e.flag = m_flag; e.fa = m_fa; e.fd = m_fd;
    sbq.push_back(e);
    prev = rd1;
    @(negedge clk);
    r = 1'b1; addr = v.a; data1 = v.d; chk_en = v.ce;
    @(negedge clk);
    r = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (rd1 != prev) seen = 1;
    end
    e = sbq.pop_front();
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL rd_timeout: rd_count stuck at %0d expected %0d", rd1, e.rd);
    end
    chk("rd_count", {112'b0, rd1}, {112'b0, e.rd});
    chk("err_count", {112'b0, err1}, {112'b0, e.err});
    chk("err_flag", {127'b0, flag1}, {127'b0, e.flag});
    chk("first_err_addr", {92'b0, fa1}, {92'b0, e.fa});
    chk("first_err_data", fd1, e.fd);
  endtask

  task automatic finish1(input logic exp_pass);
    bit seen;
    @(negedge clk) flushtype = 2'b11;
    @(negedge clk) flushtype = 2'b00;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done1) seen = 1;
      else @(negedge clk);
    end
    chk("done", {127'b0, done1}, 128'd1);
    chk("pass", {127'b0, pass1}, {127'b0, exp_pass});
    chk("final_rd", {112'b0, rd1}, {112'b0, m_rd});
    chk("final_err", {112'b0, err1}, {112'b0, m_err});
    @(negedge clk) go1 = 1'b0;
    @(negedge clk);
    chk("done_held_idle", {127'b0, done1}, 128'd1);
  endtask

  initial begin
    logic [15:0] prev;

    // Test 1: eight clean reads; test 2: error at 0x030 then 0x050;
    // test 4: corrupt data with compare disabled.
    for (int i = 0; i < 8; i++) begin
      tv[i].a  = 36'(i * 16);
      tv[i].d  = pat(36'(i * 16));
      tv[i].ce = 1'b1;
    end
    tv[8]  = '{36'h030, 128'h0, 1'b1};
    tv[9]  = '{36'h040, pat(36'h040), 1'b1};
    tv[10] = '{36'h050, {128{1'b1}}, 1'b1};
    for (int i = 11; i < 15; i++) begin
      tv[i].a  = 36'h0_0000_0800 + 36'((i - 11) * 16);
      tv[i].d  = 128'h0;
      tv[i].ce = 1'b0;
    end

    rst_n = 1'b0; go1 = 0; go3 = 0; r = 0; stall = 0; chk_en = 1;
    addr = 0; flushtype = 0; data1 = 0; data3 = 0;
    #1;
    chk("reset_rd", {112'b0, rd1}, 128'd0);
    chk("reset_done", {127'b0, done1}, 128'd0);
    chk("reset_pass", {127'b0, pass1}, 128'd0);
    @(negedge clk) rst_n = 1'b1;

    start1();
    for (int i = 0; i < 8; i++) read1(tv[i]);
    finish1(1'b1);

    start1();
    for (int i = 8; i < 11; i++) read1(tv[i]);
    finish1(1'b0);

    start1();
    for (int i = 11; i < 15; i++) read1(tv[i]);
    finish1(1'b1);

    // Test 3: stall for three cycles while the read sits in the pipe.
    start1();
    prev = rd1;
    @(negedge clk);
    r = 1'b1; addr = 36'h100; data1 = pat(36'h100); chk_en = 1'b1;
    @(negedge clk);
    r = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", {112'b0, rd1}, {112'b0, prev});
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_once", {112'b0, rd1}, {112'b0, prev + 16'd1});
    end
    m_rd++;
    chk("stall_err", {112'b0, err1}, 128'd0);

    // Test 6: bad read to dirty the state, then reset with a read in flight.
    read1('{36'h110, 128'h1234, 1'b1});
    @(negedge clk);
    r = 1'b1; addr = 36'h120; data1 = 128'h0;
    @(negedge clk);
    r = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_rd", {112'b0, rd1}, 128'd0);
    chk("rst_err", {112'b0, err1}, 128'd0);
    chk("rst_flag", {127'b0, flag1}, 128'd0);
    chk("rst_faddr", {92'b0, fa1}, 128'd0);
    chk("rst_fdata", fd1, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("rst_no_compare_rd", {112'b0, rd1}, 128'd0);
    chk("rst_no_compare_err", {112'b0, err1}, 128'd0);
    go1 = 1'b0;

    // Test 5: RD_LAT=3, flush issued with two reads in flight.
    @(negedge clk) go3 = 1'b1;
    @(negedge clk);
    r = 1'b1; addr = 36'h200; chk_en = 1'b1;
    @(negedge clk);
    addr = 36'h210; flushtype = 2'b11;
    @(negedge clk);
    r = 1'b0; flushtype = 2'b00;
    @(negedge clk);
    data3 = pat(36'h200);
    chk("lat3_rd0", {112'b0, rd3}, 128'd0);
    @(negedge clk);
    chk("lat3_rd1", {112'b0, rd3}, 128'd1);
    chk("lat3_not_done", {127'b0, done3}, 128'd0);
    data3 = pat(36'h210);
    @(negedge clk);
    chk("lat3_rd2", {112'b0, rd3}, 128'd2);
    chk("lat3_err", {112'b0, err3}, 128'd0);
    chk("lat3_done", {127'b0, done3}, 128'd1);
    chk("lat3_pass", {127'b0, pass3}, 128'd1);
    go3 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
